// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-port arbiter: opcodes,
// arbiter FSM encoding and arbitration mode constants.
package alu_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_NOR  = 3'b100;
    localparam logic [2:0] ALU_SRL  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU with zero and signed-overflow flags.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] y,
    output logic        zero,
    output logic        ovf
);

    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (op)
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_ADD: begin
                y   = sum;
                ovf = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_XOR:  y = a ^ b;
            ALU_NOR:  y = ~(a | b);
            // Shift amount is the whole of b, so anything >= 32 yields 0.
            ALU_SRL:  y = a >> b;
            ALU_SUB: begin
                y   = diff;
                ovf = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            ALU_SLTU: y = {31'd0, (a < b)};
            default:  y = '0;
        endcase
    end

    assign zero = (y == 32'd0);

endmodule

// File: rtl/alu_rr_pick.sv
// Two-way request picker: round-robin against last winner, or fixed
// priority to port 0 when prio_mode is set.
module alu_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic prio_mode,
    output logic pick_valid,
    output logic pick_id
);

    always_comb begin
        pick_valid = req0 | req1;
        pick_id    = 1'b0;
        if (req0 && req1) begin
            pick_id = prio_mode ? 1'b0 : ~last;
        end else begin
            pick_id = req1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared ALU, one operation in flight.
// Optional registered zero flag enabled by the ALU_ARB_ZERO_EN macro.
//
// state | meaning
// IDLE  | waiting for a request; grant and operand latch happen here
// EXEC  | ALU runs on latched operands; result captured at the edge
// DONE  | result valid pulse to owner; owner becomes last winner
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [2:0]  op0,
    input  logic [2:0]  op1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        vld0,
    output logic        vld1,
    output logic [31:0] res,
`ifdef ALU_ARB_ZERO_EN
    output logic        zero,
`endif
    output logic        busy
);

    arb_state_t  state;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        owner;
    logic        last;
    logic        pick_valid;
    logic        pick_id;
    logic        grant;
    logic [31:0] alu_y;
    logic        alu_zero;
    logic        unused_ovf;

    alu_rr_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last       (last),
        .prio_mode  (PRIO_MODE == PRIO_FIXED),
        .pick_valid (pick_valid),
        .pick_id    (pick_id)
    );

    alu u_alu (
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .y    (alu_y),
        .zero (alu_zero),
        .ovf  (unused_ovf)
    );

`ifndef ALU_ARB_ZERO_EN
    logic unused_zero;
    assign unused_zero = alu_zero;
`endif

    // Grant is decided in the IDLE cycle itself; held off while in reset.
    assign grant = (state == IDLE) && pick_valid && !rst;
    assign gnt0  = grant && !pick_id;
    assign gnt1  = grant && pick_id;
    assign busy  = grant || (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            vld0  <= 1'b0;
            vld1  <= 1'b0;
            res   <= '0;
`ifdef ALU_ARB_ZERO_EN
            zero  <= 1'b0;
`endif
            last  <= 1'b1;
            owner <= 1'b0;
            op_q  <= ALU_AND;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            vld0 <= 1'b0;
            vld1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        op_q  <= pick_id ? op1 : op0;
                        a_q   <= pick_id ? a1  : a0;
                        b_q   <= pick_id ? b1  : b0;
                        owner <= pick_id;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res   <= alu_y;
`ifdef ALU_ARB_ZERO_EN
                    zero  <= alu_zero;
`endif
                    vld0  <= !owner;
                    vld1  <= owner;
                    state <= DONE;
                end
                DONE: begin
                    last  <= owner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: round-robin and fixed-priority instances
// share the same stimulus.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [2:0]  op0 = '0, op1 = '0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

    logic        gnt0_r, gnt1_r, vld0_r, vld1_r, busy_r, zero_r;
    logic        gnt0_f, gnt1_f, vld0_f, vld1_f, busy_f, zero_f;
    logic [31:0] res_r, res_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.PRIO_MODE(PRIO_RR)) dut_rr (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0_r), .gnt1(gnt1_r), .vld0(vld0_r), .vld1(vld1_r),
        .res(res_r),
`ifdef ALU_ARB_ZERO_EN
        .zero(zero_r),
`endif
        .busy(busy_r)
    );

    alu_arbiter #(.PRIO_MODE(PRIO_FIXED)) dut_fx (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0_f), .gnt1(gnt1_f), .vld0(vld0_f), .vld1(vld1_f),
        .res(res_f),
`ifdef ALU_ARB_ZERO_EN
        .zero(zero_f),
`endif
        .busy(busy_f)
    );

`ifndef ALU_ARB_ZERO_EN
    assign zero_r = 1'b0;
    assign zero_f = 1'b0;
`endif

    typedef struct {
        logic        port;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " gnt0_r"}, {31'd0, gnt0_r}, 32'd0);
        chk({tag, " gnt1_r"}, {31'd0, gnt1_r}, 32'd0);
        chk({tag, " vld0_r"}, {31'd0, vld0_r}, 32'd0);
        chk({tag, " vld1_r"}, {31'd0, vld1_r}, 32'd0);
        chk({tag, " busy_r"}, {31'd0, busy_r}, 32'd0);
        chk({tag, " res_r"}, res_r, 32'd0);
        chk({tag, " zero_r"}, {31'd0, zero_r}, 32'd0);
        chk({tag, " gnt_f"}, {30'd0, gnt0_f, gnt1_f}, 32'd0);
        chk({tag, " vld_f"}, {30'd0, vld0_f, vld1_f}, 32'd0);
        chk({tag, " res_f"}, res_f, 32'd0);
    endtask

    task automatic run_op(input vec_t v, input int idx);
        string t;
        t = $sformatf("vec%0d", idx);
        @(posedge clk); #1;
        req0 = !v.port; req1 = v.port;
        op0 = v.op; a0 = v.a; b0 = v.b;
        op1 = v.op; a1 = v.a; b1 = v.b;
        @(negedge clk);
        chk({t, " gnt0"}, {31'd0, gnt0_r}, {31'd0, !v.port});
        chk({t, " gnt1"}, {31'd0, gnt1_r}, {31'd0, v.port});
        chk({t, " busy_n"}, {31'd0, busy_r}, 32'd1);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk({t, " vld_n1"}, {30'd0, vld0_r, vld1_r}, 32'd0);
        chk({t, " busy_n1"}, {31'd0, busy_r}, 32'd1);
        @(negedge clk);
        chk({t, " vld0"}, {31'd0, vld0_r}, {31'd0, !v.port});
        chk({t, " vld1"}, {31'd0, vld1_r}, {31'd0, v.port});
        chk({t, " busy_n2"}, {31'd0, busy_r}, 32'd1);
        chk({t, " res"}, res_r, v.exp_res);
        chk({t, " res_f"}, res_f, v.exp_res);
`ifdef ALU_ARB_ZERO_EN
        chk({t, " zero"}, {31'd0, zero_r}, {31'd0, v.exp_zero});
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b0, ALU_ADD,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0};
        vecs[1]  = '{1'b1, ALU_SUB,  32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{1'b0, ALU_XOR,  32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1};
        vecs[3]  = '{1'b1, ALU_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0};
        vecs[4]  = '{1'b0, ALU_OR,   32'h1200_0034, 32'h0056_7800, 32'h1256_7834, 1'b0};
        vecs[5]  = '{1'b1, ALU_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{1'b0, ALU_SRL,  32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0};
        vecs[7]  = '{1'b1, ALU_SRL,  32'hFFFF_FFFF, 32'd32,        32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, ALU_SRL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, ALU_SLTU, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 1'b0};
        vecs[10] = '{1'b0, ALU_SLTU, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[11] = '{1'b1, ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b0, ALU_SRL,  32'hF000_0000, 32'd4,         32'h0F00_0000, 1'b0};
        vecs[13] = '{1'b1, ALU_SUB,  32'h0000_1000, 32'h0000_0001, 32'h0000_0FFF, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i], i);

        // Continuous tie from reset: RR alternates, fixed always picks port 0
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        op0 = ALU_ADD; a0 = 32'd1; b0 = 32'd1;
        op1 = ALU_ADD; a1 = 32'd2; b1 = 32'd2;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("tie_rr c%0d gnt0", c), {31'd0, gnt0_r}, {31'd0, (c % 6) == 0});
            chk($sformatf("tie_rr c%0d gnt1", c), {31'd0, gnt1_r}, {31'd0, (c % 6) == 3});
            chk($sformatf("tie_rr c%0d vld0", c), {31'd0, vld0_r}, {31'd0, (c % 6) == 2});
            chk($sformatf("tie_rr c%0d vld1", c), {31'd0, vld1_r}, {31'd0, (c % 6) == 5});
            chk($sformatf("tie_fx c%0d gnt0", c), {31'd0, gnt0_f}, {31'd0, (c % 3) == 0});
            chk($sformatf("tie_fx c%0d gnt1", c), {31'd0, gnt1_f}, 32'd0);
            chk($sformatf("tie_fx c%0d vld1", c), {31'd0, vld1_f}, 32'd0);
            if ((c % 6) == 2) chk($sformatf("tie_rr c%0d res", c), res_r, 32'd2);
            if ((c % 6) == 5) chk($sformatf("tie_rr c%0d res", c), res_r, 32'd4);
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;

        // Reset while EXEC: operation dropped, held requests re-arbitrated
        @(posedge clk); #1;
        req1 = 1'b1; op1 = ALU_ADD; a1 = 32'd7; b1 = 32'd7;
        @(negedge clk);
        chk("rstx gnt1", {31'd0, gnt1_r}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        req0 = 1'b1; op0 = ALU_ADD; a0 = 32'd3; b0 = 32'd4;
        @(negedge clk);
        chk("rstx exec vld", {30'd0, vld0_r, vld1_r}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk_quiet("rstx after");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstx regrant gnt0", {31'd0, gnt0_r}, 32'd1);
        chk("rstx regrant gnt1", {31'd0, gnt1_r}, 32'd0);
        chk("rstx regrant gnt0_f", {31'd0, gnt0_f}, 32'd1);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        chk("rstx n1 vld", {30'd0, vld0_r, vld1_r}, 32'd0);
        @(negedge clk);
        chk("rstx n2 vld0", {31'd0, vld0_r}, 32'd1);
        chk("rstx n2 vld1", {31'd0, vld1_r}, 32'd0);
        chk("rstx n2 res", res_r, 32'd7);
        @(negedge clk);
        chk("rstx next gnt1", {31'd0, gnt1_r}, 32'd1);
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstx p1 vld1", {31'd0, vld1_r}, 32'd1);
        chk("rstx p1 res", res_r, 32'd14);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
